// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
// Holds the FSM state encoding and the bundled enable/clear control word.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DFLT = 5;
    localparam int MC_CNT_W_DFLT   = 4;
    localparam int PERF_W_DFLT     = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LAST   = 2'd2,
        ST_HALTED = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_clr;
        logic idex_clr;
        logic exmem_clr;
        logic memwb_clr;
    } pipe_ctl_t;

    // Everything advances, nothing is cleared.
    localparam pipe_ctl_t CTL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_clr: 1'b0, idex_clr: 1'b0, exmem_clr: 1'b0, memwb_clr: 1'b0
    };

    // Front end and EX frozen while the multi-cycle op occupies EX; a bubble goes into MEM.
    localparam pipe_ctl_t CTL_MC_STALL = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_clr: 1'b0, idex_clr: 1'b0, exmem_clr: 1'b1, memwb_clr: 1'b0
    };

    localparam pipe_ctl_t CTL_HALT = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_clr: 1'b0, idex_clr: 1'b0, exmem_clr: 1'b0, memwb_clr: 1'b0
    };

    localparam pipe_ctl_t CTL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_clr: 1'b1, idex_clr: 1'b1, exmem_clr: 1'b1, memwb_clr: 1'b1
    };

endpackage

// File: rtl/pipe_mc_counter.sv
// Remaining-stall counter for multi-cycle EX ops: loads N-2 at the start cycle,
// counts down while the FSM sits in BUSY, flags the final BUSY cycle.
module pipe_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = MC_CNT_W_DFLT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [MC_CNT_W-1:0] total_cycles,
    output logic                last_stall
);

    logic [MC_CNT_W-1:0] cnt_q;
    logic [MC_CNT_W-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = total_cycles - MC_CNT_W'(2);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_stall = (cnt_q == MC_CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/flush controller driving pipeline-register EN/CLR and PC write enable.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
    parameter int MC_CNT_W   = MC_CNT_W_DFLT,
    parameter int PERF_W     = PERF_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  idex_is_load,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  ex_redirect,
    input  logic                  ex_mc_start,
    input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
    input  logic                  wb_halt,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  exmem_clr,
    output logic                  memwb_clr,
    output logic                  halted,
    output logic [PERF_W-1:0]     perf_stall,
    output logic [PERF_W-1:0]     perf_flush,
    output logic [PERF_W-1:0]     perf_mc
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    pipe_ctl_t   ctl_hz;
    pipe_ctl_t   ctl;
    pipe_ctl_t   ctl_out;
    logic        load_use;
    logic        mc_long;
    logic        mc_load;
    logic        mc_dec;
    logic        mc_last;

    assign load_use = idex_is_load && (idex_rd != '0) &&
                      ((id_use_rs && (id_rs == idex_rd)) ||
                       (id_use_rt && (id_rt == idex_rd)));

    assign mc_long = ex_mc_start && (ex_mc_cycles >= MC_CNT_W'(2));

    // Redirect flushes the wrong-path instructions and wins over a load-use stall.
    always_comb begin
        ctl_hz = CTL_RUN;
        if (ex_redirect) begin
            ctl_hz.ifid_clr = 1'b1;
            ctl_hz.idex_clr = 1'b1;
        end else if (load_use) begin
            ctl_hz.pc_en    = 1'b0;
            ctl_hz.ifid_en  = 1'b0;
            ctl_hz.idex_clr = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = CTL_RUN;
        mc_load = 1'b0;
        mc_dec  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (wb_halt) begin
                    state_d = ST_HALTED;
                end else if (ex_redirect) begin
                    ctl = ctl_hz;
                end else if (mc_long) begin
                    ctl     = CTL_MC_STALL;
                    mc_load = 1'b1;
                    state_d = (ex_mc_cycles == MC_CNT_W'(2)) ? ST_LAST : ST_BUSY;
                end else begin
                    ctl = ctl_hz;
                end
            end
            ST_BUSY: begin
                ctl    = CTL_MC_STALL;
                mc_dec = 1'b1;
                if (wb_halt) begin
                    state_d = ST_HALTED;
                end else if (mc_last) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (wb_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    ctl     = ctl_hz;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                ctl = CTL_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_mc_counter #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (mc_load),
        .dec          (mc_dec),
        .total_cycles (ex_mc_cycles),
        .last_stall   (mc_last)
    );

    // While reset is held the registers see a bubble on every stage, independent of state.
    assign ctl_out = rst_n ? ctl : CTL_RESET;

    assign pc_en     = ctl_out.pc_en;
    assign ifid_en   = ctl_out.ifid_en;
    assign idex_en   = ctl_out.idex_en;
    assign exmem_en  = ctl_out.exmem_en;
    assign memwb_en  = ctl_out.memwb_en;
    assign ifid_clr  = ctl_out.ifid_clr;
    assign idex_clr  = ctl_out.idex_clr;
    assign exmem_clr = ctl_out.exmem_clr;
    assign memwb_clr = ctl_out.memwb_clr;
    assign halted    = (state_q == ST_HALTED);

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q;
    logic [PERF_W-1:0] perf_flush_d;
    logic [PERF_W-1:0] perf_mc_q;
    logic [PERF_W-1:0] perf_mc_d;

    // ifid_clr is raised only by an applied redirect; counters wrap naturally.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_mc_d    = perf_mc_q;
        if ((state_q != ST_HALTED) && !ctl.pc_en) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
        if (ctl.ifid_clr) begin
            perf_flush_d = perf_flush_q + PERF_W'(1);
        end
        if (mc_load) begin
            perf_mc_d = perf_mc_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_mc_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mc_q    <= perf_mc_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    assign perf_mc    = perf_mc_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_mc    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect priority, multi-cycle
// stalls, sticky halt, asynchronous reset and the optional performance counters.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Control word order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem, memwb clears.
    localparam logic [8:0] V_RUN  = 9'b11111_0000;
    localparam logic [8:0] V_LU   = 9'b00111_0100;
    localparam logic [8:0] V_FL   = 9'b11111_1100;
    localparam logic [8:0] V_MC   = 9'b00011_0010;
    localparam logic [8:0] V_HALT = 9'b00000_0000;
    localparam logic [8:0] V_RST  = 9'b00000_1111;

    typedef struct packed {
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [8:0] exp;
    } lu_row_t;

    localparam lu_row_t LU_TAB [5] = '{
        '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, V_LU},
        '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, V_RUN},
        '{1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, V_LU},
        '{1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, V_RUN},
        '{1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, V_RUN}
    };

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        idex_is_load;
    logic [4:0]  idex_rd;
    logic        ex_redirect;
    logic        ex_mc_start;
    logic [3:0]  ex_mc_cycles;
    logic        wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic        halted;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
    logic [31:0] perf_mc;
    logic [8:0]  ctl_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int exp_mc = 0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MC_CNT_W   (4),
        .PERF_W     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .idex_is_load (idex_is_load),
        .idex_rd      (idex_rd),
        .ex_redirect  (ex_redirect),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_clr     (ifid_clr),
        .idex_clr     (idex_clr),
        .exmem_clr    (exmem_clr),
        .memwb_clr    (memwb_clr),
        .halted       (halted),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_mc      (perf_mc)
    );

    assign ctl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_clr, idex_clr, exmem_clr, memwb_clr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs        = '0;
        id_rt        = '0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        idex_is_load = 1'b0;
        idex_rd      = '0;
        ex_redirect  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_cycles = '0;
        wb_halt      = 1'b0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({halted, ctl_vec} !== {1'b0, V_RST}) begin
            n_bad++;
            $display("FAIL reset_outputs: got halted=%b ctl=%b, want halted=0 ctl=%b", halted, ctl_vec, V_RST);
        end
        n_cmp++;
        if ({perf_stall, perf_flush, perf_mc} !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_perf: got %0d/%0d/%0d, want 0/0/0", perf_stall, perf_flush, perf_mc);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_RUN) begin
            n_bad++;
            $display("FAIL reset_release: got ctl=%b, want %b", ctl_vec, V_RUN);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            idex_is_load = LU_TAB[i].ld;
            idex_rd      = LU_TAB[i].rd;
            id_rs        = LU_TAB[i].rs;
            id_rt        = LU_TAB[i].rt;
            id_use_rs    = LU_TAB[i].urs;
            id_use_rt    = LU_TAB[i].urt;
            if (LU_TAB[i].exp == V_LU) exp_stall++;
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== LU_TAB[i].exp) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got ctl=%b, want %b", i, ctl_vec, LU_TAB[i].exp);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        // Load-use and redirect together: flush, no stall.
        idex_is_load = 1'b1;
        idex_rd      = 5'd5;
        id_rs        = 5'd5;
        id_use_rs    = 1'b1;
        ex_redirect  = 1'b1;
        exp_flush++;
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_FL) begin
            n_bad++;
            $display("FAIL redirect_vs_load_use: got ctl=%b, want %b", ctl_vec, V_FL);
        end
        next_cycle();
        // Redirect and a multi-cycle start together: redirect wins, no stall begins.
        idle_inputs();
        ex_redirect  = 1'b1;
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 4'd4;
        exp_flush++;
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_FL) begin
            n_bad++;
            $display("FAIL redirect_vs_mc: got ctl=%b, want %b", ctl_vec, V_FL);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_RUN) begin
            n_bad++;
            $display("FAIL redirect_after: got ctl=%b, want %b", ctl_vec, V_RUN);
        end
        next_cycle();
    endtask

    task automatic test_mc_n4();
        logic [8:0] exp_seq [4];
        exp_seq = '{V_MC, V_MC, V_MC, V_RUN};
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 4'd4;
        exp_stall += 3;
        exp_mc++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL mc_n4[%0d]: got ctl=%b, want %b", i, ctl_vec, exp_seq[i]);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_RUN) begin
            n_bad++;
            $display("FAIL mc_n4_run: got ctl=%b, want %b", ctl_vec, V_RUN);
        end
        next_cycle();
    endtask

    task automatic test_mc_short();
        logic [8:0] seq2 [3];
        logic [8:0] seq1 [3];
        logic [8:0] seq5 [6];
        seq2 = '{V_MC, V_RUN, V_RUN};
        seq1 = '{V_RUN, V_RUN, V_RUN};
        seq5 = '{V_MC, V_MC, V_MC, V_MC, V_RUN, V_RUN};
        // N=2: start cycle is the only stall.
        exp_stall += 1;
        exp_mc++;
        for (int i = 0; i < 3; i++) begin
            ex_mc_start  = (i < 2);
            ex_mc_cycles = 4'd2;
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== seq2[i]) begin
                n_bad++;
                $display("FAIL mc_n2[%0d]: got ctl=%b, want %b", i, ctl_vec, seq2[i]);
            end
            next_cycle();
        end
        // N=1: no stall at all.
        for (int i = 0; i < 3; i++) begin
            ex_mc_start  = (i < 2);
            ex_mc_cycles = 4'd1;
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== seq1[i]) begin
                n_bad++;
                $display("FAIL mc_n1[%0d]: got ctl=%b, want %b", i, ctl_vec, seq1[i]);
            end
            next_cycle();
        end
        // N=5 with a redirect pulse while BUSY: four stalls, redirect ignored.
        exp_stall += 4;
        exp_mc++;
        for (int i = 0; i < 6; i++) begin
            ex_mc_start  = (i < 5);
            ex_mc_cycles = 4'd5;
            ex_redirect  = (i == 1);
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== seq5[i]) begin
                n_bad++;
                $display("FAIL mc_n5[%0d]: got ctl=%b, want %b", i, ctl_vec, seq5[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_perf(input string tag);
        int want_s;
        int want_f;
        int want_m;
        want_s = PERF_ON ? exp_stall : 0;
        want_f = PERF_ON ? exp_flush : 0;
        want_m = PERF_ON ? exp_mc : 0;
        @(negedge clk);
        n_cmp++;
        if (perf_stall !== 32'(want_s)) begin
            n_bad++;
            $display("FAIL perf_stall_%s: got %0d, want %0d", tag, perf_stall, want_s);
        end
        n_cmp++;
        if (perf_flush !== 32'(want_f)) begin
            n_bad++;
            $display("FAIL perf_flush_%s: got %0d, want %0d", tag, perf_flush, want_f);
        end
        n_cmp++;
        if (perf_mc !== 32'(want_m)) begin
            n_bad++;
            $display("FAIL perf_mc_%s: got %0d, want %0d", tag, perf_mc, want_m);
        end
        next_cycle();
    endtask

    task automatic test_halt();
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 4'd6;
        exp_stall += 2;
        exp_mc++;
        @(negedge clk);
        n_cmp++;
        if (ctl_vec !== V_MC) begin
            n_bad++;
            $display("FAIL halt_mc_start: got ctl=%b, want %b", ctl_vec, V_MC);
        end
        next_cycle();
        wb_halt = 1'b1;
        next_cycle();
        // Halted: other inputs keep toggling and must be ignored.
        for (int i = 0; i < 20; i++) begin
            wb_halt      = (i % 5 == 0);
            ex_redirect  = i[0];
            ex_mc_start  = i[1];
            ex_mc_cycles = 4'd3;
            idex_is_load = 1'b1;
            idex_rd      = 5'd9;
            id_rs        = 5'd9;
            id_use_rs    = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({halted, ctl_vec} !== {1'b1, V_HALT}) begin
                n_bad++;
                $display("FAIL halt_hold[%0d]: got halted=%b ctl=%b, want halted=1 ctl=%b", i, halted, ctl_vec, V_HALT);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({halted, ctl_vec} !== {1'b0, V_RST}) begin
            n_bad++;
            $display("FAIL unhalt_reset: got halted=%b ctl=%b, want halted=0 ctl=%b", halted, ctl_vec, V_RST);
        end
        next_cycle();
        rst_n = 1'b1;
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 4'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== V_MC) begin
                n_bad++;
                $display("FAIL busy_n6[%0d]: got ctl=%b, want %b", i, ctl_vec, V_MC);
            end
            if (i == 0) next_cycle();
        end
        // Drop reset in stall cycle 2, away from any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({halted, ctl_vec} !== {1'b0, V_RST}) begin
            n_bad++;
            $display("FAIL mid_busy_reset: got halted=%b ctl=%b, want halted=0 ctl=%b", halted, ctl_vec, V_RST);
        end
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl_vec !== V_RUN) begin
                n_bad++;
                $display("FAIL post_reset_run[%0d]: got ctl=%b, want %b", i, ctl_vec, V_RUN);
            end
            next_cycle();
        end
        exp_stall = 0;
        exp_flush = 0;
        exp_mc    = 0;
        test_perf("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_load_use();
        test_redirect();
        test_mc_n4();
        test_mc_short();
        test_perf("pre_halt");
        test_halt();
        test_perf("halted");
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard/flush controller for the 5-stage ideal pipeline.
- Drives the EN/CLR inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- It is the control side of the pipeline-register interface: pipeline registers consume EN/CLR, this block produces them.
- Resolves four conditions: load-use stalls, taken-branch flushes, multi-cycle EX ops (mul/div) and a sticky halt.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MC_CNT_W, 4, width of the multi-cycle latency field and counter.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- idex_is_load  in  1  instruction in EX is a load.
- idex_rd  in  REG_ADDR_W  destination of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- ex_mc_start  in  1  EX holds a multi-cycle op; level signal.
- ex_mc_cycles  in  MC_CNT_W  total EX occupancy N of that op.
- wb_halt  in  1  halt instruction retiring in WB.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clears (bubble insert).
- halted  out  1  sticky halt indication.
- perf_stall, perf_flush, perf_mc  out  PERF_W each  performance counters.

Behaviour:
- Outputs are combinational from state plus inputs.
- State is updated on posedge clk; rst_n clears state asynchronously.
- Reset (rst_n=0): state RUN, counter 0, halted=0, perf counters 0; all *_en=0 and all *_clr=1.
- States: RUN, BUSY, LAST, HALTED.
- Default output in RUN/LAST: all en=1, all clr=0.
- Priority within RUN: wb_halt > ex_redirect > ex_mc_start (N>=2) > load-use.
- Load-use hazard condition: idex_is_load AND idex_rd!=0 AND ((id_use_rs AND id_rs==idex_rd) OR (id_use_rt AND id_rt==idex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_clr=1, for one cycle. No state change.
- ex_redirect: ifid_clr=1, idex_clr=1, pc_en=1. Overrides any load-use stall in the same cycle.
- Multi-cycle op, taken in RUN when ex_mc_start=1 and N>=2:
  - Stall for exactly N-1 cycles: pc_en=ifid_en=idex_en=0, exmem_clr=1 (bubble into MEM). MEM/WB continue.
  - Start cycle is stall cycle 1. Counter loads N-2; next state is LAST if N==2, else BUSY.
  - BUSY: stall outputs. If counter==1 go LAST, else decrement counter.
  - LAST: normal advance; ex_mc_start is ignored; next state RUN.
  - N of 0 or 1: no stall.
  - ex_redirect and load-use are ignored in BUSY.
- wb_halt in any state: next state HALTED and halted=1.
  - HALTED: all en=0, all clr=0; exits only via reset.
- Reset asserted mid-BUSY: immediate return to RUN; the counter is discarded.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With the macro defined:
  - perf_stall increments each cycle pc_en=0 outside reset/HALTED.
  - perf_flush increments each applied ex_redirect.
  - perf_mc increments on each accepted multi-cycle start.
  - All counters wrap at 2^PERF_W.
- Without the macro: the perf ports exist and are tied to 0, and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN/BUSY/LAST/HALTED);
  - REG_ADDR_W and MC_CNT_W default constants;
  - a struct bundling the nine enable/clear outputs.
- One natural sub-module, pipe_mc_counter: holds the load/decrement/terminal-count logic for the multi-cycle counter.

Test Plan:
- Load-use: idex_is_load=1, idex_rd=5, id_use_rs=1, id_rs=5 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; with idex_rd=0 -> no stall.
- Redirect vs load-use in same cycle: both conditions true -> ifid_clr=1, idex_clr=1, pc_en=1, no stall.
- Multi-cycle N=4: ex_mc_start held high -> exactly 3 stall cycles with exmem_clr=1, then one advance cycle (LAST), then RUN; perf_mc=1 when PIPE_HAZARD_PERF_EN is defined.
- Multi-cycle N=2 and N=1: N=2 -> exactly 1 stall cycle; N=1 -> none; ex_redirect pulsed during BUSY (N=5) -> ignored.
- Halt: wb_halt pulsed during BUSY -> HALTED next cycle, all en=0, halted=1 held for 20 cycles despite other inputs.
- Reset mid-BUSY: drop rst_n at cycle 2 of N=6 -> all en=0/clr=1 immediately; after release -> RUN with all en=1; with PIPE_HAZARD_PERF_EN defined, perf counters read 0.
